rf_arbiter: RTL
===============

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 SHALL have parameter AW, default `REG_ADDR_WIDTH (2), register address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  2  per-requester access request; bit0 = core, bit1 = debug.
REQ-006 SHALL have port we  input  2  per-requester op select; 1 = store, 0 = load.
REQ-007 SHALL have port addr  input  2*AW  per-requester register address; requester i occupies slice [i*AW +: AW].
REQ-008 SHALL have port wdata  input  2*DW  per-requester store data; requester i occupies slice [i*DW +: DW].
REQ-009 SHALL have port gnt  output  2  one-cycle one-hot pulse: winner's request accepted.
REQ-010 SHALL have port wdone  output  2  one-cycle one-hot pulse: store committed.
REQ-011 SHALL have port rvalid  output  2  one-cycle one-hot pulse: rdata valid for that requester.
REQ-012 SHALL have port rdata  output  DW  load result, shared; held until next load completes.
REQ-013 SHALL have port rf_ld_ce  output  1  load strobe to register file.
REQ-014 SHALL have port rf_st_ce  output  1  store strobe to register file.
REQ-015 SHALL have port rf_addr  output  AW  register file address.
REQ-016 SHALL have port rf_acc  output  DW  store data to register file.
REQ-017 SHALL have port rf_data  input  DW  register file read data, registered, valid one cycle after rf_ld_ce.

Function
REQ-018 SHALL register all outputs; no combinational input-to-output path.
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT; req sampled only in IDLE.
REQ-020 IDLE with req != 0: SHALL pick winner, latch its we/addr/wdata, set gnt[w], assert rf_ld_ce (we=0) or rf_st_ce (we=1) with rf_addr/rf_acc, go ISSUE; all visible next cycle.
REQ-021 Arbitration SHALL be round-robin: single requester wins outright; both requesting -> grant the one not granted last; after reset, core wins the first tie.
REQ-022 ISSUE (strobe high exactly this cycle): store -> SHALL set wdone[w], go IDLE; load -> go WAIT.
REQ-023 WAIT: SHALL capture rf_data into rdata, set rvalid[w], go IDLE.
REQ-024 Latency from req sampled (cycle 0): gnt + strobe in cycle 1; wdone in cycle 2; rvalid/rdata in cycle 3.
REQ-025 Throughput: new grant possible in cycle 2 after a store, cycle 3 after a load (same cycle as rvalid).
REQ-026 Requester SHALL hold req/we/addr/wdata until gnt; dropping req before grant withdraws it, with no side effect.
REQ-027 req still high in the cycle after its gnt SHALL not be re-granted before returning to IDLE; a held req is a new request.
REQ-028 Address passes unchanged; address 3 (R3) reads whatever rf_data returns, with no special casing.
REQ-029 rf_ld_ce and rf_st_ce SHALL never both be high; at most one bit of gnt|wdone|rvalid per vector.
REQ-030 rf_addr/rf_acc SHALL hold the last issued value when no strobe is active.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE; gnt, wdone, rvalid, rf_ld_ce, rf_st_ce = 0; rdata, rf_addr, rf_acc = 0; RR pointer to favour core.
REQ-032 Reset in ISSUE/WAIT SHALL discard the operation, with no wdone/rvalid afterwards. A strobe already sampled by the register file is not undone.

Verification
REQ-033 Core store addr=1 data=0xA5 -> gnt=01 and rf_st_ce, rf_addr=1, rf_acc=0xA5 in cycle 1; wdone=01 in cycle 2.
REQ-034 Debug load addr=1 after REQ-033 -> rf_ld_ce cycle 1; rvalid=10, rdata=0xA5 in cycle 3.
REQ-035 Both req held continuously with loads -> grants alternate 01,10,01,... starting with core after reset; no starvation.
REQ-036 Core req drops in the same cycle debug raises req (IDLE) -> debug granted; core gets nothing.
REQ-037 rst_n low during WAIT -> outputs 0 immediately; no rvalid after release; next request is served normally.
REQ-038 Random mix of requests against a register-file model -> every rdata matches the last committed store; strobes are mutually exclusive.

Source files
------------

// File: rtl/rf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_arbiter
// Description : Round-robin core/debug arbiter in front of a single-port
//               register file. All outputs are registered.
// Revision    : 1.0
// ============================================================================
module rf_arbiter #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      wdone,
    output logic [1:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            rf_ld_ce,
    output logic            rf_st_ce,
    output logic [AW-1:0]   rf_addr,
    output logic [DW-1:0]   rf_acc,
    input  logic [DW-1:0]   rf_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          op_we_q, op_we_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    wdone_q, wdone_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ld_q, ld_d;
    logic          st_q, st_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] acc_q, acc_d;

    logic          w_pick;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic [1:0]    w_win_vec;

    // On a tie the requester that was not granted last wins.
    assign w_pick      = (req == 2'b11) ? ~last_q : req[1];
    assign w_sel_addr  = w_pick ? addr[AW +: AW]  : addr[0 +: AW];
    assign w_sel_wdata = w_pick ? wdata[DW +: DW] : wdata[0 +: DW];
    assign w_win_vec   = {win_q, ~win_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            op_we_q  <= 1'b0;
            gnt_q    <= 2'b00;
            wdone_q  <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            addr_q   <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            op_we_q  <= op_we_d;
            gnt_q    <= gnt_d;
            wdone_q  <= wdone_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ld_q     <= ld_d;
            st_q     <= st_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req != 2'b00) state_d = S_ISSUE;
            S_ISSUE: state_d = op_we_q ? S_IDLE : S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        win_d    = win_q;
        last_d   = last_q;
        op_we_d  = op_we_q;
        gnt_d    = 2'b00;
        wdone_d  = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        ld_d     = 1'b0;
        st_d     = 1'b0;
        addr_d   = addr_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    win_d   = w_pick;
                    last_d  = w_pick;
                    op_we_d = we[w_pick];
                    gnt_d   = {w_pick, ~w_pick};
                    st_d    = we[w_pick];
                    ld_d    = ~we[w_pick];
                    addr_d  = w_sel_addr;
                    if (we[w_pick]) acc_d = w_sel_wdata;
                end
            end
            S_ISSUE: begin
                if (op_we_q) wdone_d = w_win_vec;
            end
            S_WAIT: begin
                rdata_d  = rf_data;
                rvalid_d = w_win_vec;
            end
            default: ;
        endcase
    end

    assign gnt      = gnt_q;
    assign wdone    = wdone_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rf_ld_ce = ld_q;
    assign rf_st_ce = st_q;
    assign rf_addr  = addr_q;
    assign rf_acc   = acc_q;

endmodule
`default_nettype wire
